// File: rtl/m2_pattern_filler.sv
// M2 pattern filler: serves one word per request edge, either a pattern word from
// the lowest-index matching channel or the fill word on a miss or gated slot.
module m2_pattern_filler #(
    parameter int                    WORD_W      = 12,
    parameter int                    PTR_W       = 8,
    parameter int                    CH          = 6,
    parameter int                    CNT_W       = 10,
    parameter logic [CH*PTR_W-1:0]   CH_BASE     = {CH{PTR_W'(8'd80)}},
    parameter logic [CH*PTR_W-1:0]   CH_MASK     = {CH*PTR_W{1'b1}},
    parameter logic [CH-1:0]         CH_ODD_ONLY = {CH{1'b1}},
    parameter logic [CH*2-1:0]       CH_MODE     = {CH*2{1'b0}},
    parameter logic [CNT_W-1:0]      LFSR_TAPS   = CNT_W'(10'h240),
    parameter logic [WORD_W-1:0]     FILL_WORD   = WORD_W'(12'h002)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bufGetWord,
    input  logic [PTR_W-1:0]  bufRdPointer,
    input  logic              grpOddity,
    input  logic              patEnable,
    input  logic              cntClear,
    output logic [WORD_W-1:0] dataWord,
    output logic              wordStrobe,
    output logic [CH-1:0]     chHit,
    output logic [CH-1:0]     chWrap
);

    localparam int         PAD_W     = WORD_W - 1 - CNT_W;
    localparam logic [1:0] MODE_UP   = 2'd0;
    localparam logic [1:0] MODE_DOWN = 2'd1;
    localparam logic [1:0] MODE_LFSR = 2'd2;
    localparam logic [1:0] MODE_WALK = 2'd3;

    function automatic logic [CNT_W-1:0] seedOf(input logic [1:0] mode);
        logic [CNT_W-1:0] res;
        case (mode)
            MODE_UP:   res = {CNT_W{1'b0}};
            MODE_DOWN: res = {CNT_W{1'b1}};
            MODE_LFSR: res = CNT_W'(1'b1);
            MODE_WALK: res = CNT_W'(1'b1);
            default:   res = CNT_W'(1'b1);
        endcase
        return res;
    endfunction

    // A stuck all-zero LFSR state would never leave zero, so it reloads the seed.
    function automatic logic [CNT_W-1:0] advanceOf(input logic [1:0] mode,
                                                   input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        case (mode)
            MODE_UP:   res = val + CNT_W'(1'b1);
            MODE_DOWN: res = val - CNT_W'(1'b1);
            MODE_LFSR: res = (val == {CNT_W{1'b0}}) ? CNT_W'(1'b1)
                                                    : {val[CNT_W-2:0], ^(val & LFSR_TAPS)};
            MODE_WALK: res = {val[CNT_W-2:0], val[CNT_W-1]};
            default:   res = val;
        endcase
        return res;
    endfunction

    logic                 reqPrev;
    logic [CNT_W-1:0]     patReg  [CH];
    logic [CNT_W-1:0]     nextVal [CH];
    logic [CNT_W-1:0]     seedVal [CH];
    logic [CH-1:0]        matchVec;
    logic [CH-1:0]        winOneHot;
    logic [CH-1:0]        wrapHit;
    logic [CNT_W-1:0]     winVal;
    logic [WORD_W-1:0]    hitWord;
    logic                 reqEvent;
    logic                 winValid;
    logic                 gated;
    logic                 serve;

    // Per-channel slot match, next-value and seed computation.
    always_comb begin
        matchVec = {CH{1'b0}};
        for (int i = 0; i < CH; i++) begin
            seedVal[i]  = seedOf(CH_MODE[i*2 +: 2]);
            nextVal[i]  = advanceOf(CH_MODE[i*2 +: 2], patReg[i]);
            matchVec[i] = ((bufRdPointer & CH_MASK[i*PTR_W +: PTR_W]) ==
                           (CH_BASE[i*PTR_W +: PTR_W] & CH_MASK[i*PTR_W +: PTR_W]));
        end
    end

    // Lowest matching index wins; isolate it as a one-hot and decide service.
    always_comb begin
        winVal    = {CNT_W{1'b0}};
        wrapHit   = {CH{1'b0}};
        winOneHot = matchVec & (~matchVec + CH'(1'b1));
        for (int i = 0; i < CH; i++) begin
            winVal     = winVal | (winOneHot[i] ? patReg[i] : {CNT_W{1'b0}});
            wrapHit[i] = winOneHot[i] & (nextVal[i] == seedVal[i]);
        end
        hitWord  = WORD_W'(winVal) << PAD_W;
        reqEvent = bufGetWord & ~reqPrev;
        winValid = |matchVec;
        gated    = ~patEnable | ((|(winOneHot & CH_ODD_ONLY)) & ~grpOddity);
        serve    = reqEvent & winValid & ~gated;
    end

    // Request-edge tracking and output registers; reqPrev resets high so a held request never fires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reqPrev    <= 1'b1;
            dataWord   <= {WORD_W{1'b0}};
            wordStrobe <= 1'b0;
            chHit      <= {CH{1'b0}};
            chWrap     <= {CH{1'b0}};
        end else begin
            reqPrev    <= bufGetWord;
            wordStrobe <= reqEvent;
            chHit      <= serve ? winOneHot : {CH{1'b0}};
            chWrap     <= (serve & ~cntClear) ? wrapHit : {CH{1'b0}};
            if (reqEvent) begin
                dataWord <= serve ? hitWord : FILL_WORD;
            end
        end
    end

    // Pattern registers: a clear overrides the advance of a coincident served request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CH; i++) begin
                patReg[i] <= seedOf(CH_MODE[i*2 +: 2]);
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (cntClear) begin
                    patReg[i] <= seedVal[i];
                end else if (serve && winOneHot[i]) begin
                    patReg[i] <= nextVal[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_m2_pattern_filler.sv
// Bench for m2_pattern_filler: directed and random requests scored against a
// behavioural model through an expectation queue drained by a separate monitor.
module tb_m2_pattern_filler;

    localparam int WORD_W = 12;
    localparam int PTR_W  = 8;
    localparam int CH     = 6;
    localparam int CNT_W  = 10;
    localparam int FILL   = 'h002;

    localparam logic [CH*PTR_W-1:0] T_BASE = {8'd100, 8'd1, 8'hC0, 8'd80, 8'd26, 8'd26};
    localparam logic [CH*PTR_W-1:0] T_MASK = {8'hFF, 8'h03, 8'hFC, 8'hFF, 8'hFF, 8'hFF};
    localparam logic [CH-1:0]       T_ODD  = 6'b000100;
    localparam logic [CH*2-1:0]     T_MODE = {2'd2, 2'd0, 2'd1, 2'd0, 2'd0, 2'd3};

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              bufGetWord = 1'b0;
    logic [PTR_W-1:0]  bufRdPointer = 8'd0;
    logic              grpOddity = 1'b0;
    logic              patEnable = 1'b0;
    logic              cntClear = 1'b0;
    logic [WORD_W-1:0] dataWord;
    logic              wordStrobe;
    logic [CH-1:0]     chHit;
    logic [CH-1:0]     chWrap;

    m2_pattern_filler #(
        .WORD_W(WORD_W), .PTR_W(PTR_W), .CH(CH), .CNT_W(CNT_W),
        .CH_BASE(T_BASE), .CH_MASK(T_MASK), .CH_ODD_ONLY(T_ODD), .CH_MODE(T_MODE),
        .LFSR_TAPS(10'h240), .FILL_WORD(12'h002)
    ) dut (
        .clk(clk), .reset(reset), .bufGetWord(bufGetWord), .bufRdPointer(bufRdPointer),
        .grpOddity(grpOddity), .patEnable(patEnable), .cntClear(cntClear),
        .dataWord(dataWord), .wordStrobe(wordStrobe), .chHit(chHit), .chWrap(chWrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WORD_W-1:0] word;
        logic [CH-1:0]     hit;
        logic [CH-1:0]     wrap;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Channel table: ch0 walk@26, ch1 up@26 (shadowed), ch2 up@80 odd-only,
    // ch3 down@C0..C3, ch4 up@xxxxxx01, ch5 LFSR@100.
    int mBase[CH] = '{26, 26, 80, 'hC0, 1, 100};
    int mMask[CH] = '{'hFF, 'hFF, 'hFF, 'hFC, 'h03, 'hFF};
    int mMode[CH] = '{3, 0, 0, 1, 0, 2};
    int mOdd[CH]  = '{0, 0, 1, 0, 0, 0};
    int mReg[CH];
    bit mPrev;

    function automatic int seedOf(input int md);
        if (md == 1) return 1023;
        if (md == 0) return 0;
        return 1;
    endfunction

    function automatic int advance(input int md, input int v);
        case (md)
            0: return (v + 1) % 1024;
            1: return (v + 1023) % 1024;
            2: begin
                if (v == 0) return 1;
                return ((v * 2) % 1024) | ($countones(v & 'h240) % 2);
            end
            3: return ((v * 2) % 1024) | (v / 512);
            default: return v;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < CH; i++) mReg[i] = seedOf(mMode[i]);
        mPrev = 1'b1;
        q.delete();
    endtask

    // What the next rising edge must do, given the inputs now applied.
    task automatic modelStep(input bit bgw, input int ptr, input bit odd, input bit en, input bit clr);
        exp_t e;
        int   win;
        int   nxt;
        win = -1;
        if (bgw && !mPrev) begin
            for (int i = CH - 1; i >= 0; i--)
                if ((ptr & mMask[i]) == (mBase[i] & mMask[i])) win = i;
            e.word = WORD_W'(FILL);
            e.hit  = '0;
            e.wrap = '0;
            if (win >= 0 && en && (mOdd[win] == 0 || odd)) begin
                e.word = WORD_W'(mReg[win] * 2);
                e.hit  = CH'(1 << win);
                nxt    = advance(mMode[win], mReg[win]);
                if (!clr && nxt == seedOf(mMode[win])) e.wrap = CH'(1 << win);
                mReg[win] = nxt;
            end
            q.push_back(e);
        end
        if (clr) for (int i = 0; i < CH; i++) mReg[i] = seedOf(mMode[i]);
        mPrev = bgw;
    endtask

    task automatic drive(input bit bgw, input int ptr, input bit odd, input bit en, input bit clr);
        @(negedge clk);
        bufGetWord   = bgw;
        bufRdPointer = PTR_W'(ptr);
        grpOddity    = odd;
        patEnable    = en;
        cntClear     = clr;
        modelStep(bgw, ptr, odd, en, clr);
    endtask

    task automatic request(input int ptr, input bit odd, input bit en, input bit clr,
                           input int hold, input int low);
        drive(1'b1, ptr, odd, en, clr);
        for (int k = 1; k < hold; k++) drive(1'b1, ptr, odd, en, 1'b0);
        for (int k = 0; k < low; k++) drive(1'b0, ptr, odd, en, 1'b0);
    endtask

    task automatic doReset(input bit bgw, input int cycles);
        @(negedge clk);
        reset      = 1'b0;
        bufGetWord = bgw;
        cntClear   = 1'b0;
        modelReset();
        repeat (cycles) @(negedge clk);
        reset = 1'b1;
        modelStep(bgw, int'(bufRdPointer), grpOddity, patEnable, 1'b0);
    endtask

    // Monitor: sample just after each rising edge and score against the queue.
    logic [WORD_W-1:0] lastWord = '0;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                chk("reset_dataWord", 32'(dataWord), 32'd0);
                chk("reset_strobe", 32'(wordStrobe), 32'd0);
                chk("reset_chHit", 32'(chHit), 32'd0);
                chk("reset_chWrap", 32'(chWrap), 32'd0);
                lastWord = '0;
            end else if (wordStrobe) begin
                if (q.size() == 0) begin
                    chk("spurious_strobe", 32'(wordStrobe), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("dataWord", 32'(dataWord), 32'(e.word));
                    chk("chHit", 32'(chHit), 32'(e.hit));
                    chk("chWrap", 32'(chWrap), 32'(e.wrap));
                    lastWord = e.word;
                end
            end else begin
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("missing_strobe", 32'(wordStrobe), 32'd1);
                end
                chk("idle_chHit", 32'(chHit), 32'd0);
                chk("idle_chWrap", 32'(chWrap), 32'd0);
                chk("idle_hold", 32'(dataWord), 32'(lastWord));
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    int pool[10] = '{26, 80, 'hC0, 'hC1, 'hC3, 1, 5, 100, 3, 0};

    initial begin
        int ptr;
        modelReset();
        doReset(1'b0, 3);

        // Odd-only up counter, gating by parity, held request, miss.
        repeat (3) request(80, 1'b1, 1'b1, 1'b0, 1, 1);
        request(80, 1'b0, 1'b1, 1'b0, 1, 1);
        request(80, 1'b1, 1'b1, 1'b0, 1, 1);
        request(80, 1'b1, 1'b1, 1'b0, 5, 1);
        request(3, 1'b1, 1'b1, 1'b0, 1, 1);
        // Masked channel, priority pair, down counter, LFSR.
        request(1, 1'b0, 1'b1, 1'b0, 1, 1);
        request(5, 1'b0, 1'b1, 1'b0, 1, 1);
        request(9, 1'b0, 1'b1, 1'b0, 1, 1);
        repeat (4) request(26, 1'b0, 1'b1, 1'b0, 1, 1);
        repeat (2) request('hC1, 1'b0, 1'b1, 1'b0, 1, 1);
        repeat (3) request(100, 1'b0, 1'b1, 1'b0, 1, 1);
        request(100, 1'b0, 1'b1, 1'b1, 1, 1);
        request(100, 1'b0, 1'b1, 1'b0, 1, 1);
        request(80, 1'b1, 1'b0, 1'b0, 1, 1);
        drive(1'b0, 0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b1, 1'b0);

        // Full wrap of each register kind.
        repeat (1025) request(1, 1'b0, 1'b1, 1'b0, 1, 1);
        repeat (1024) request(100, 1'b0, 1'b1, 1'b0, 1, 1);
        repeat (12) request(26, 1'b0, 1'b1, 1'b0, 1, 1);
        repeat (1025) request('hC0, 1'b0, 1'b1, 1'b0, 1, 1);

        // Reset while a request is held high: no event until a fresh rising edge.
        drive(1'b1, 80, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 80, 1'b1, 1'b1, 1'b0);
        doReset(1'b1, 2);
        repeat (4) drive(1'b1, 80, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 80, 1'b1, 1'b1, 1'b0);
        request(80, 1'b1, 1'b1, 1'b0, 1, 1);

        // Randomized traffic.
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 10) == 10) ptr = int'($urandom_range(0, 255));
            else ptr = pool[$urandom_range(0, 9)];
            request(ptr, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 29) == 0), int'($urandom_range(1, 3)),
                    int'($urandom_range(1, 2)));
            if ($urandom_range(0, 39) == 0) drive(1'b0, ptr, 1'b0, 1'b1, 1'b1);
        end

        repeat (3) drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
